// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial 8-digit packed-BCD adder computing A + B + Cin,
// least-significant digit first, one digit per clock, with START/BUSY/DONE handshake.
// Optional invalid-digit checking is built when BCD_SERIAL_ADDER_CHECK_EN is defined;
// otherwise ERR is tied low.
module bcd_serial_adder (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Cin,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] S,
   output logic        Cout,
   output logic        ERR
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ADD  = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [2:0]  cnt_r;
   logic [31:0] a_sh_r;
   logic [31:0] b_sh_r;
   logic        carry_r;
   logic [31:0] res_r;
   logic [4:0]  add_s;
   logic        start_s;
   logic        last_s;
   logic        busy_nxt_s;
   logic        done_nxt_s;

   // Single decimal-adjust cell: returns {carry_out, digit}
   function automatic logic [4:0] digit_adjust(input logic [3:0] da,
                                                input logic [3:0] db,
                                                input logic       dc);
      logic [4:0] t;
      logic [4:0] adj;
      t   = {1'b0, da} + {1'b0, db} + {4'b0000, dc};
      adj = t + 5'd6;
      if (t > 5'd9) begin
         digit_adjust = {1'b1, adj[3:0]};
      end else begin
         digit_adjust = {1'b0, t[3:0]};
      end
   endfunction

   assign add_s   = digit_adjust(a_sh_r[3:0], b_sh_r[3:0], carry_r);
   assign start_s = (state_r == ST_IDLE) && START;
   assign last_s  = (state_r == ST_ADD) && (cnt_r == 3'd7);

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode: accept START only in IDLE, leave ADD after digit 7
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (START) begin
               state_nxt_s = ST_ADD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ADD: begin
            if (cnt_r == 3'd7) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ADD;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode: next values for the registered handshake outputs
   always_comb begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      case (state_nxt_s)
         ST_ADD:  busy_nxt_s = 1'b1;
         ST_IDLE: busy_nxt_s = 1'b0;
         default: busy_nxt_s = 1'b0;
      endcase
      if (last_s) begin
         done_nxt_s = 1'b1;
      end else begin
         done_nxt_s = 1'b0;
      end
   end

   // Handshake output registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         BUSY <= 1'b0;
         DONE <= 1'b0;
      end else begin
         BUSY <= busy_nxt_s;
         DONE <= done_nxt_s;
      end
   end

   // Operand capture, digit shifting and digit counter
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a_sh_r  <= 32'h0000_0000;
         b_sh_r  <= 32'h0000_0000;
         carry_r <= 1'b0;
         res_r   <= 32'h0000_0000;
         cnt_r   <= 3'd0;
      end else if (start_s) begin
         a_sh_r  <= A;
         b_sh_r  <= B;
         carry_r <= Cin;
         res_r   <= 32'h0000_0000;
         cnt_r   <= 3'd0;
      end else if (state_r == ST_ADD) begin
         a_sh_r  <= {4'h0, a_sh_r[31:4]};
         b_sh_r  <= {4'h0, b_sh_r[31:4]};
         carry_r <= add_s[4];
         res_r   <= {add_s[3:0], res_r[31:4]};
         cnt_r   <= cnt_r + 3'd1;
      end
   end

   // Result registers: updated only on the completion edge
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         S    <= 32'h0000_0000;
         Cout <= 1'b0;
      end else if (last_s) begin
         S    <= {add_s[3:0], res_r[31:4]};
         Cout <= add_s[4];
      end
   end

`ifdef BCD_SERIAL_ADDER_CHECK_EN
   logic err_flag_r;
   logic digit_bad_s;

   // True when a packed digit lies outside 0..9
   function automatic logic digit_invalid(input logic [3:0] d);
      digit_invalid = (d > 4'd9);
   endfunction

   assign digit_bad_s = digit_invalid(a_sh_r[3:0]) | digit_invalid(b_sh_r[3:0]);

   // Sticky per-operation invalid-digit flag, published with the result
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         err_flag_r <= 1'b0;
         ERR        <= 1'b0;
      end else if (start_s) begin
         err_flag_r <= 1'b0;
      end else if (state_r == ST_ADD) begin
         err_flag_r <= err_flag_r | digit_bad_s;
         if (last_s) begin
            ERR <= err_flag_r | digit_bad_s;
         end
      end
   end
`else
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed vectors, random operands against
// a digit-arithmetic reference model, back-to-back START, mid-operation reset,
// invalid-digit flagging and START-while-busy rejection.
module tb_bcd_serial_adder;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic [31:0] A;
   logic [31:0] B;
   logic        Cin;
   logic        BUSY;
   logic        DONE;
   logic [31:0] S;
   logic        Cout;
   logic        ERR;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef BCD_SERIAL_ADDER_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   always #5 CLK = ~CLK;

   bcd_serial_adder dut (
      .CLK  (CLK),
      .RST  (RST),
      .START(START),
      .A    (A),
      .B    (B),
      .Cin  (Cin),
      .BUSY (BUSY),
      .DONE (DONE),
      .S    (S),
      .Cout (Cout),
      .ERR  (ERR)
   );

   // Reference: decimal digit addition with the +6 adjust rule, digit by digit
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 output logic [31:0] s, output logic co, output logic bad);
      int c;
      int da, db, t, d;
      c = int'(cin);
      s = 32'h0;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         da = int'((a >> (4 * i)) & 32'hF);
         db = int'((b >> (4 * i)) & 32'hF);
         t = da + db + c;
         if (t > 9) begin
            d = (t + 6) % 16;
            c = 1;
         end else begin
            d = t;
            c = 0;
         end
         s = s | (32'(d) << (4 * i));
         if (da > 9 || db > 9) bad = 1'b1;
      end
      co = (c != 0);
   endfunction

   function automatic logic [31:0] rand_bcd();
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < 8; i++) v = v | (32'($urandom_range(0, 9)) << (4 * i));
      return v;
   endfunction

   // Called at a negedge with DUT idle; returns at the negedge after the START edge
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cin);
      A = a;
      B = b;
      Cin = cin;
      START = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
   endtask

   // Waits (bounded) for DONE; lat = edges after START edge, -1 on timeout
   task automatic wait_done(output int lat, output int busy_cnt);
      lat = -1;
      busy_cnt = BUSY ? 1 : 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (DONE) begin
            lat = i;
            break;
         end
         if (BUSY) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || S !== 32'h0 || Cout !== 1'b0 || ERR !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: BUSY=%b DONE=%b S=%h Cout=%b ERR=%b, required all zero",
                  BUSY, DONE, S, Cout, ERR);
      end
   endtask

   task automatic test_directed();
      logic [31:0] va[6] = '{32'h12345678, 32'h99999999, 32'h00000000, 32'h0000000A, 32'h00000001, 32'h00000000};
      logic [31:0] vb[6] = '{32'h87654321, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000};
      logic        vc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] vs[6] = '{32'h99999999, 32'h00000000, 32'h00000001, 32'h00000010, 32'h00000002, 32'h00000000};
      logic        vo[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        ve[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int lat, bc;
      logic [31:0] s_hold;
      for (int i = 0; i < 6; i++) begin
         start_op(va[i], vb[i], vc[i]);
         wait_done(lat, bc);
         n_cmp++;
         if (lat !== 8 || bc !== 8) begin
            n_bad++;
            $display("FAIL directed%0d_timing: latency=%0d busy_cycles=%0d, required 8/8", i, lat, bc);
         end
         n_cmp++;
         if (S !== vs[i] || Cout !== vo[i]) begin
            n_bad++;
            $display("FAIL directed%0d_sum: S=%h Cout=%b, required S=%h Cout=%b", i, S, Cout, vs[i], vo[i]);
         end
         n_cmp++;
         if (ERR !== (ve[i] & CHECK_EN)) begin
            n_bad++;
            $display("FAIL directed%0d_err: ERR=%b, required %b", i, ERR, ve[i] & CHECK_EN);
         end
         s_hold = S;
         @(posedge CLK);
         @(negedge CLK);
         n_cmp++;
         if (DONE !== 1'b0 || BUSY !== 1'b0 || S !== s_hold) begin
            n_bad++;
            $display("FAIL directed%0d_after: DONE=%b BUSY=%b S=%h, required 0/0/%h", i, DONE, BUSY, S, s_hold);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, es;
      logic c, eo, eb;
      int lat, bc;
      for (int i = 0; i < 24; i++) begin
         a = ($urandom_range(0, 3) == 0) ? $urandom : rand_bcd();
         b = ($urandom_range(0, 3) == 0) ? $urandom : rand_bcd();
         c = 1'($urandom_range(0, 1));
         model(a, b, c, es, eo, eb);
         start_op(a, b, c);
         wait_done(lat, bc);
         n_cmp++;
         if (lat !== 8 || S !== es || Cout !== eo || ERR !== (eb & CHECK_EN)) begin
            n_bad++;
            $display("FAIL random%0d: a=%h b=%h c=%b lat=%0d S=%h Cout=%b ERR=%b, required lat=8 S=%h Cout=%b ERR=%b",
                     i, a, b, c, lat, S, Cout, ERR, es, eo, eb & CHECK_EN);
         end
         @(posedge CLK);
         @(negedge CLK);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, dones, last;
      cyc = 0;
      dones = 0;
      last = 0;
      A = 32'h50000000;
      B = 32'h50000000;
      Cin = 1'b0;
      START = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         cyc++;
         if (DONE) begin
            n_cmp++;
            if (S !== 32'h0 || Cout !== 1'b1) begin
               n_bad++;
               $display("FAIL b2b_sum%0d: S=%h Cout=%b, required 00000000/1", dones, S, Cout);
            end
            if (dones > 0) begin
               n_cmp++;
               if (cyc - last !== 9) begin
                  n_bad++;
                  $display("FAIL b2b_interval: %0d cycles, required 9", cyc - last);
               end
            end
            last = cyc;
            dones++;
            A = 32'h50000000;
            B = 32'h50000000;
            Cin = 1'b0;
            if (dones == 3) break;
         end else if (BUSY) begin
            A = $urandom;
            B = $urandom;
            Cin = 1'($urandom_range(0, 1));
         end
      end
      START = 1'b0;
      n_cmp++;
      if (dones !== 3) begin
         n_bad++;
         $display("FAIL b2b_count: %0d completions, required 3", dones);
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic test_reset_mid();
      int lat, bc, dcnt;
      start_op(32'h12345678, 32'h87654321, 1'b0);
      wait_done(lat, bc);
      n_cmp++;
      if (S !== 32'h99999999) begin
         n_bad++;
         $display("FAIL rstmid_pre: S=%h, required 99999999", S);
      end
      start_op(32'h00000005, 32'h00000004, 1'b0);
      repeat (3) begin
         @(posedge CLK);
         @(negedge CLK);
      end
      RST = 1'b1;
      #1;
      n_cmp++;
      if (S !== 32'h0 || BUSY !== 1'b0 || DONE !== 1'b0 || Cout !== 1'b0 || ERR !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_now: S=%h BUSY=%b DONE=%b Cout=%b ERR=%b, required all zero",
                  S, BUSY, DONE, Cout, ERR);
      end
      @(negedge CLK);
      RST = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (DONE || BUSY) dcnt++;
      end
      n_cmp++;
      if (dcnt !== 0 || S !== 32'h0) begin
         n_bad++;
         $display("FAIL rstmid_after: %0d DONE/BUSY cycles S=%h, required 0 and 00000000", dcnt, S);
      end
   endtask

   task automatic test_overlap();
      logic [31:0] a, b, es;
      logic c, eo, eb;
      int dcnt;
      a = rand_bcd();
      b = rand_bcd();
      c = 1'($urandom_range(0, 1));
      model(a, b, c, es, eo, eb);
      start_op(a, b, c);
      dcnt = 0;
      for (int i = 1; i <= 24; i++) begin
         if (i == 2 || i == 5 || i == 7) begin
            A = $urandom;
            B = $urandom;
            Cin = 1'($urandom_range(0, 1));
            START = 1'b1;
         end else begin
            START = 1'b0;
         end
         @(posedge CLK);
         @(negedge CLK);
         if (DONE) dcnt++;
      end
      START = 1'b0;
      n_cmp++;
      if (dcnt !== 1 || S !== es || Cout !== eo) begin
         n_bad++;
         $display("FAIL overlap: dones=%0d S=%h Cout=%b, required 1 S=%h Cout=%b", dcnt, S, Cout, es, eo);
      end
   endtask

   initial begin
      RST = 1'b1;
      START = 1'b0;
      A = 32'h0;
      B = 32'h0;
      Cin = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_overlap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
